// File: rtl/wb_burst_master.sv
// -----------------------------------------------------------------------------
// wb_burst_master
//
// Wishbone B3 initiator. One command from a valid/ready command port becomes
// either a classic single cycle (len==0) or a registered-feedback burst
// (CTI 010 ... 111) with linear or wrapping addressing (BTE), read or write.
// Write beats come in on a valid/ready stream. Read beats go out as one-cycle
// pulses with no backpressure.
//
// Handshake rule for every valid/ready pair in this block (cmd_*, wr_*): a
// transfer happens on the rising clock edge where valid and ready are both
// high. Valid, once raised, keeps its payload stable until that edge. Ready may
// depend combinationally on current inputs: wr_ready_o looks at wb_ack_i so a
// new beat can replace the acknowledged one with no bubble.
//
// Parameters
//   aw : byte address width of wb_adr_o / cmd_adr_i (must be >= 6)
//   lw : width of cmd_len_i; burst length = cmd_len_i + 1 beats
//
// Ports
//   wb_clk_i, wb_rst_ni         clock (rising edge), async active-low reset
//   cmd_valid_i / cmd_ready_o   command handshake; ready only while idle
//   cmd_we_i, cmd_adr_i,        write flag, start byte address (bits [1:0]
//   cmd_len_i, cmd_bte_i        forced to 0), beats-1, burst type
//   wr_data_i / wr_valid_i /    write beat stream
//   wr_ready_o
//   rd_data_o / rd_valid_o      registered read beat, one-cycle pulse
//   done_o / done_err_o         end-of-command pulse; err flag valid with it
//   wb_* outputs                registered wishbone initiator signals
//   wb_dat_i/wb_ack_i/wb_err_i  wishbone responder inputs
//   dbg_state_o                 current FSM state (0 idle, 1 bus)
// -----------------------------------------------------------------------------
module wb_burst_master #(
  parameter int aw = 32,
  parameter int lw = 4
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,

  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [aw-1:0] cmd_adr_i,
  input  logic [lw-1:0] cmd_len_i,
  input  logic [1:0]    cmd_bte_i,

  input  logic [31:0]   wr_data_i,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,

  output logic [31:0]   rd_data_o,
  output logic          rd_valid_o,
  output logic          done_o,
  output logic          done_err_o,

  output logic [aw-1:0] wb_adr_o,
  output logic [31:0]   wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic [2:0]    wb_cti_o,
  output logic [1:0]    wb_bte_o,
  input  logic [31:0]   wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,

  output logic          dbg_state_o
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUS  = 1'b1
  } state_e;

  localparam logic [2:0]  CTI_CLASSIC = 3'b000;
  localparam logic [2:0]  CTI_INCR    = 3'b010;
  localparam logic [2:0]  CTI_END     = 3'b111;
  localparam logic [lw-1:0] REM_ONE   = {{(lw-1){1'b0}}, 1'b1};
  localparam logic [lw:0]   FETCH_ONE = {{lw{1'b0}}, 1'b1};
  localparam logic [aw-1:0] ADR_STEP  = {{(aw-3){1'b0}}, 3'b100};

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [1:0]    bte_q, bte_d;
  logic [aw-1:0] adr_q, adr_d;
  logic [lw-1:0] rem_q, rem_d;       // acks still expected after the current beat
  logic [lw:0]   fetch_q, fetch_d;   // write beats still to pull from wr_*
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic [2:0]    cti_q, cti_d;
  logic          hold_full_q, hold_full_d;
  logic [31:0]   dat_q, dat_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          done_q, done_d;
  logic          done_err_q, done_err_d;

  logic beat_ack;
  logic beat_err;
  logic last_beat;
  logic wr_ready;
  logic wr_fire;

  // Next beat address. Wrapping bursts only step the low word-index bits
  // inside the aligned 4/8/16-word block; linear steps the whole address and
  // rolls over at 2^aw.
  function automatic logic [aw-1:0] next_adr(input logic [aw-1:0] a,
                                             input logic [1:0]    bte);
    logic [aw-1:0] inc;
    logic [aw-1:0] mask;
    inc = a + ADR_STEP;
    case (bte)
      2'b01:   mask = {{(aw-6){1'b0}}, 6'h0c};
      2'b10:   mask = {{(aw-6){1'b0}}, 6'h1c};
      2'b11:   mask = {{(aw-6){1'b0}}, 6'h3c};
      default: mask = '1;
    endcase
    return (a & ~mask) | (inc & mask);
  endfunction

  // Responses only count while a strobe is out; err wins over ack.
  assign beat_err  = cyc_q & stb_q & wb_err_i;
  assign beat_ack  = cyc_q & stb_q & wb_ack_i & ~wb_err_i;
  assign last_beat = (rem_q == '0);

  // A new write beat fits when the holding register is empty or is being
  // emptied by this cycle's ack.
  assign wr_ready = (state_q == S_BUS) & we_q & (fetch_q != '0) &
                    (~hold_full_q | beat_ack);
  assign wr_fire  = wr_valid_i & wr_ready;

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    bte_d       = bte_q;
    adr_d       = adr_q;
    rem_d       = rem_q;
    fetch_d     = fetch_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    cti_d       = cti_q;
    hold_full_d = hold_full_q;
    dat_d       = dat_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    done_d      = 1'b0;
    done_err_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          state_d     = S_BUS;
          we_d        = cmd_we_i;
          bte_d       = cmd_bte_i;
          adr_d       = {cmd_adr_i[aw-1:2], 2'b00};
          rem_d       = cmd_len_i;
          fetch_d     = {1'b0, cmd_len_i} + FETCH_ONE;
          cyc_d       = 1'b1;
          // Reads strobe at once; writes wait for the first beat.
          stb_d       = ~cmd_we_i;
          cti_d       = (cmd_len_i == '0) ? CTI_CLASSIC : CTI_INCR;
          hold_full_d = 1'b0;
        end
      end

      S_BUS: begin
        if (beat_err) begin
          // Abort: drop the bus and any pending write beat.
          state_d     = S_IDLE;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          cti_d       = CTI_CLASSIC;
          hold_full_d = 1'b0;
          fetch_d     = '0;
          done_d      = 1'b1;
          done_err_d  = 1'b1;
        end else begin
          if (we_q) begin
            if (wr_fire) begin
              hold_full_d = 1'b1;
              dat_d       = wr_data_i;
              fetch_d     = fetch_q - FETCH_ONE;
            end else if (beat_ack) begin
              hold_full_d = 1'b0;
            end
            // Write strobe simply mirrors holding-register occupancy, which
            // produces wait states when the write stream stalls.
            stb_d = hold_full_d;
          end

          if (beat_ack) begin
            adr_d = next_adr(adr_q, bte_q);
            if (!we_q) begin
              rd_data_d  = wb_dat_i;
              rd_valid_d = 1'b1;
            end
            if (last_beat) begin
              state_d     = S_IDLE;
              cyc_d       = 1'b0;
              stb_d       = 1'b0;
              cti_d       = CTI_CLASSIC;
              hold_full_d = 1'b0;
              done_d      = 1'b1;
            end else begin
              rem_d = rem_q - REM_ONE;
              // The beat that follows is the final one when one ack remains.
              cti_d = (rem_q == REM_ONE) ? CTI_END : CTI_INCR;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      bte_q       <= 2'b00;
      adr_q       <= '0;
      rem_q       <= '0;
      fetch_q     <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      cti_q       <= CTI_CLASSIC;
      hold_full_q <= 1'b0;
      dat_q       <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      done_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      bte_q       <= bte_d;
      adr_q       <= adr_d;
      rem_q       <= rem_d;
      fetch_q     <= fetch_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      cti_q       <= cti_d;
      hold_full_q <= hold_full_d;
      dat_q       <= dat_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      done_err_q  <= done_err_d;
    end
  end

  assign cmd_ready_o = (state_q == S_IDLE);
  assign wr_ready_o  = wr_ready;
  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign done_o      = done_q;
  assign done_err_o  = done_err_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = 4'hf;
  assign wb_we_o     = we_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = stb_q;
  assign wb_cti_o    = cti_q;
  assign wb_bte_o    = bte_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_burst_master.sv
module tb_wb_burst_master;

  localparam int AW = 8;
  localparam int LW = 4;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_adr;
  logic [LW-1:0] cmd_len;
  logic [1:0]    cmd_bte;
  logic [31:0]   wr_data;
  logic          wr_valid, wr_ready;
  logic [31:0]   rd_data;
  logic          rd_valid, done, done_err;
  logic [AW-1:0] wb_adr;
  logic [31:0]   wb_dat_o, wb_dat_i;
  logic [3:0]    wb_sel;
  logic          wb_we, wb_cyc, wb_stb;
  logic [2:0]    wb_cti;
  logic [1:0]    wb_bte;
  logic          wb_ack, wb_err;
  logic          dbg_state;

  wb_burst_master #(.aw(AW), .lw(LW)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_len_i(cmd_len), .cmd_bte_i(cmd_bte),
    .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .done_o(done), .done_err_o(done_err),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel), .wb_we_o(wb_we),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_cti_o(wb_cti), .wb_bte_o(wb_bte),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack), .wb_err_i(wb_err),
    .dbg_state_o(dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard
  typedef struct {
    logic [AW-1:0] adr;
    logic          we;
    logic [2:0]    cti;
    logic [1:0]    bte;
    logic [31:0]   dat;
    logic          last;
  } beat_t;

  beat_t       exp_bus_q[$];
  logic [31:0] exp_q[$];        // expected read data
  logic        exp_done_q[$];   // expected done_err per command

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int cur_err = -1;
  int slv_ack_pct = 100;
  logic [31:0] cur_seed = 32'h0;
  logic mon_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Responder memory content: a pure function of address and a per-command seed.
  function automatic logic [31:0] rd_word(input logic [AW-1:0] a, input logic [31:0] seed);
    return {seed[23:0], a} ^ 32'h1357_9bdf;
  endfunction

  // Reference address of beat i: wrapping bursts cycle through the aligned
  // block of n words, linear bursts count up modulo 2^AW.
  function automatic logic [AW-1:0] model_adr(input int start, input int bte, input int i);
    int n, blk, base, off;
    if (bte == 0) return AW'(start + 4 * i);
    n    = 4 << (bte - 1);
    blk  = n * 4;
    base = start - (start % blk);
    off  = (start % blk) / 4;
    return AW'(base + ((off + i) % n) * 4);
  endfunction

  // ---------------------------------------------------------------- responder
  int slv_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      wb_ack  = 1'b0;
      wb_err  = 1'b0;
      slv_cnt = 0;
    end else begin
      wb_ack = 1'b0;
      wb_err = 1'b0;
      if (!wb_cyc) slv_cnt = 0;
      if (wb_cyc && wb_stb) begin
        if (slv_cnt == cur_err) begin
          wb_err = 1'b1;
          wb_ack = 1'($urandom_range(0, 1));
          slv_cnt++;
        end else if ($urandom_range(0, 99) < slv_ack_pct) begin
          wb_ack = 1'b1;
          slv_cnt++;
        end
      end else begin
        // stray response with no strobe out; the master must ignore it
        wb_ack = ($urandom_range(0, 3) == 0);
      end
      wb_dat_i = rd_word(wb_adr, cur_seed);
    end
  end

  // ---------------------------------------------------------------- monitor
  logic          prev_cyc = 0, prev_resp = 0, prev_term = 0, prev_rd_ack = 0;
  logic [AW-1:0] prev_adr = '0;
  logic [2:0]    prev_cti = '0;

  always @(negedge clk) begin
    #1;
    if (!rst_n || !mon_en) begin
      prev_cyc = 0; prev_resp = 0; prev_term = 0; prev_rd_ack = 0;
    end else begin
      beat_t e;
      logic  resp;
      if (rd_valid || prev_rd_ack) check("rd_valid_timing", 32'(rd_valid), 32'(prev_rd_ack));
      if (rd_valid) begin
        if (exp_q.size() == 0) fail_now("rd_valid_unexpected");
        else check("rd_data", rd_data, exp_q.pop_front());
      end
      if (done || prev_term) check("done_timing", 32'(done), 32'(prev_term));
      if (done) begin
        check("done_cyc_low", 32'(wb_cyc), 32'd0);
        check("cmd_ready_after_done", 32'(cmd_ready), 32'd1);
        if (exp_done_q.size() == 0) fail_now("done_unexpected");
        else check("done_err", 32'(done_err), 32'(exp_done_q.pop_front()));
        done_cnt++;
      end
      if (wb_cyc && prev_cyc && !prev_resp) begin
        check("adr_hold", 32'(wb_adr), 32'(prev_adr));
        check("cti_hold", 32'(wb_cti), 32'(prev_cti));
      end
      resp = wb_cyc && wb_stb && (wb_ack || wb_err);
      if (resp) begin
        check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
        if (exp_bus_q.size() == 0) begin
          fail_now("bus_beat_unexpected");
          prev_term = 0;
          prev_rd_ack = 0;
        end else begin
          e = exp_bus_q.pop_front();
          check("wb_adr", 32'(wb_adr), 32'(e.adr));
          check("wb_we", 32'(wb_we), 32'(e.we));
          check("wb_cti", 32'(wb_cti), 32'(e.cti));
          check("wb_bte", 32'(wb_bte), 32'(e.bte));
          check("wb_sel", 32'(wb_sel), 32'hf);
          if (e.we) check("wb_dat", wb_dat_o, e.dat);
          prev_term   = e.last;
          prev_rd_ack = !e.we && !wb_err;
        end
      end else begin
        prev_term   = 0;
        prev_rd_ack = 0;
      end
      prev_resp = resp;
      prev_cyc  = wb_cyc;
      prev_adr  = wb_adr;
      prev_cti  = wb_cti;
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic run_cmd(input logic we, input logic [AW-1:0] adr, input int len,
                         input logic [1:0] bte, input int err_beat,
                         input int wr_pct, input int ack_pct);
    int          nbeats, hs, cyc_cnt, d0, start;
    logic        take;
    logic [31:0] wd[$];
    beat_t       b;
    start       = int'(adr) & ~3;
    cur_seed    = $urandom;
    cur_err     = err_beat;
    slv_ack_pct = ack_pct;
    nbeats      = (err_beat >= 0) ? err_beat + 1 : len + 1;
    for (int i = 0; i <= len; i++) wd.push_back($urandom);
    for (int i = 0; i < nbeats; i++) begin
      b.adr  = model_adr(start, int'(bte), i);
      b.we   = we;
      b.cti  = (len == 0) ? 3'b000 : ((i == len) ? 3'b111 : 3'b010);
      b.bte  = bte;
      b.dat  = wd[i];
      b.last = (i == nbeats - 1);
      exp_bus_q.push_back(b);
      if (!we && i != err_beat) exp_q.push_back(rd_word(b.adr, cur_seed));
    end
    exp_done_q.push_back(err_beat >= 0);
    d0 = done_cnt;

    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr | AW'($urandom_range(0, 3));
    cmd_len   = LW'(len);
    cmd_bte   = bte;
    #2;
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;

    hs = 0;
    cyc_cnt = 0;
    while (done_cnt == d0 && cyc_cnt < 400) begin
      if (we && hs <= len && $urandom_range(0, 99) < wr_pct) begin
        wr_valid = 1'b1;
        wr_data  = wd[hs];
      end else begin
        wr_valid = 1'b0;
      end
      #2;
      take = wr_valid && wr_ready;
      @(posedge clk);
      if (take) hs++;
      @(negedge clk);
      cyc_cnt++;
    end
    wr_valid = 1'b0;
    if (cyc_cnt >= 400) fail_now("done_timeout");
    check("wr_handshakes", 32'(hs), we ? 32'(nbeats) : 32'd0);
    check("bus_q_drained", 32'(exp_bus_q.size()), 32'd0);
    check("rd_q_drained", 32'(exp_q.size()), 32'd0);
    exp_bus_q.delete();
    exp_q.delete();
    exp_done_q.delete();
    cur_err = -1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_cyc"}, 32'(wb_cyc), 32'd0);
    check({tag, "_stb"}, 32'(wb_stb), 32'd0);
    check({tag, "_we"}, 32'(wb_we), 32'd0);
    check({tag, "_cti"}, 32'(wb_cti), 32'd0);
    check({tag, "_bte"}, 32'(wb_bte), 32'd0);
    check({tag, "_adr"}, 32'(wb_adr), 32'd0);
    check({tag, "_dat"}, wb_dat_o, 32'd0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_done_err"}, 32'(done_err), 32'd0);
    check({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    cmd_valid = 0; cmd_we = 0; cmd_adr = '0; cmd_len = '0; cmd_bte = '0;
    wr_data = '0; wr_valid = 0; wb_dat_i = '0; wb_ack = 0; wb_err = 0;
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_cmd(1'b0, 8'h40, 3, 2'b00, -1, 100, 100);  // linear read, full speed
    run_cmd(1'b1, 8'h08, 3, 2'b01, -1, 100, 100);  // wrap4 write 08,0C,00,04
    run_cmd(1'b0, 8'h20, 0, 2'b00, -1, 100, 100);  // classic single read
    run_cmd(1'b1, 8'h60, 7, 2'b00, -1, 50, 100);   // write with stream stalls
    run_cmd(1'b0, 8'h80, 7, 2'b00, 2, 100, 100);   // error on third beat
    run_cmd(1'b0, 8'hF8, 3, 2'b00, -1, 100, 100);  // linear rollover F8,FC,00,04
    run_cmd(1'b1, 8'h74, 15, 2'b11, -1, 70, 60);   // wrap16 write
    run_cmd(1'b1, 8'h34, 7, 2'b10, 4, 80, 80);     // wrap8 write with error

    for (int k = 0; k < 40; k++) begin
      int len, eb;
      len = $urandom_range(0, 15);
      eb  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len) : -1;
      run_cmd(1'($urandom_range(0, 1)), AW'($urandom_range(0, 255)), len,
              2'($urandom_range(0, 3)), eb, $urandom_range(40, 100),
              $urandom_range(40, 100));
    end

    // Reset in the middle of a burst: outputs clear without waiting for a clock.
    mon_en = 1'b0;
    cur_err = -1;
    slv_ack_pct = 50;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 8'h30; cmd_len = 4'd15; cmd_bte = 2'b00;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("midburst_cyc_before_reset", 32'(wb_cyc), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    run_cmd(1'b0, 8'hC0, 3, 2'b01, -1, 100, 100);  // recovery after reset

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
